// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates, active-low syncs, active-video flag and frame-start strobe.
// Optional macro SYNC_DELAY_EN adds one pix_en-gated register stage on hsync/vsync/active.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 32'd640,
    parameter int unsigned H_FP     = 32'd16,
    parameter int unsigned H_SYNC   = 32'd96,
    parameter int unsigned H_BP     = 32'd48,
    parameter int unsigned V_ACTIVE = 32'd480,
    parameter int unsigned V_FP     = 32'd10,
    parameter int unsigned V_SYNC   = 32'd2,
    parameter int unsigned V_BP     = 32'd33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    output logic [9:0] vga_x,
    output logic [9:0] vga_y,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       frame_start
);

    localparam logic [9:0] H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 32'd1);
    localparam logic [9:0] V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 32'd1);
    localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_LO = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_HI = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_LO = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_HI = 10'(V_ACTIVE + V_FP + V_SYNC);

    function automatic logic in_window(input logic [9:0] cnt, input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (cnt >= lo) && (cnt < hi);
    endfunction

    logic [9:0] h_cnt_r, v_cnt_r;
    logic [9:0] h_nxt_s, v_nxt_s;
    logic       hsync_nxt_s, vsync_nxt_s, active_nxt_s, frame_nxt_s;
    logic       hsync_r, vsync_r, active_r, frame_start_r;

    // Raster position after one pixel advance.
    always_comb begin
        h_nxt_s = h_cnt_r;
        v_nxt_s = v_cnt_r;
        if (h_cnt_r == H_LAST) begin
            h_nxt_s = 10'd0;
            if (v_cnt_r == V_LAST) begin
                v_nxt_s = 10'd0;
            end else begin
                v_nxt_s = v_cnt_r + 10'd1;
            end
        end else begin
            h_nxt_s = h_cnt_r + 10'd1;
        end
    end

    // Decode from the next position so the registered flags line up with the counters.
    always_comb begin
        hsync_nxt_s  = ~in_window(h_nxt_s, H_SYNC_LO, H_SYNC_HI);
        vsync_nxt_s  = ~in_window(v_nxt_s, V_SYNC_LO, V_SYNC_HI);
        active_nxt_s = (h_nxt_s < H_ACT) && (v_nxt_s < V_ACT);
        frame_nxt_s  = (h_nxt_s == 10'd0) && (v_nxt_s == 10'd0);
    end

    // Counter and decoded-flag registers; reset parks on the last blanking pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r       <= H_LAST;
            v_cnt_r       <= V_LAST;
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            active_r      <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (pix_en) begin
            h_cnt_r       <= h_nxt_s;
            v_cnt_r       <= v_nxt_s;
            hsync_r       <= hsync_nxt_s;
            vsync_r       <= vsync_nxt_s;
            active_r      <= active_nxt_s;
            frame_start_r <= frame_nxt_s;
        end else begin
            frame_start_r <= 1'b0;
        end
    end

    assign vga_x       = h_cnt_r;
    assign vga_y       = v_cnt_r;
    assign frame_start = frame_start_r;

`ifdef SYNC_DELAY_EN
    logic hsync_d_r, vsync_d_r, active_d_r;

    // One-pixel lag to match the sprite detectors' registered hit latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_d_r  <= 1'b1;
            vsync_d_r  <= 1'b1;
            active_d_r <= 1'b0;
        end else if (pix_en) begin
            hsync_d_r  <= hsync_r;
            vsync_d_r  <= vsync_r;
            active_d_r <= active_r;
        end
    end

    assign hsync  = hsync_d_r;
    assign vsync  = vsync_d_r;
    assign active = active_d_r;
`else
    assign hsync  = hsync_r;
    assign vsync  = vsync_r;
    assign active = active_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a linear pixel-index model predicts every cycle for a default-timing
// instance and a tiny-timing instance (full frames within a short run).
module tb_vga_timing_gen;

    localparam int HA [2] = '{640, 8};
    localparam int HF [2] = '{16, 2};
    localparam int HS [2] = '{96, 3};
    localparam int HB [2] = '{48, 2};
    localparam int VA [2] = '{480, 4};
    localparam int VF [2] = '{10, 1};
    localparam int VS [2] = '{2, 2};
    localparam int VB [2] = '{33, 1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_en = 1'b0;

    logic [9:0] x0, y0, x1, y1;
    logic hs0, vs0, act0, fs0, hs1, vs1, act1, fs1;

    vga_timing_gen dut0 (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .vga_x(x0), .vga_y(y0), .hsync(hs0), .vsync(vs0), .active(act0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .vga_x(x1), .vga_y(y1), .hsync(hs1), .vsync(vs1), .active(act1), .frame_start(fs1)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [23:0] q0 [$];
    logic [23:0] q1 [$];

    // Model state: linear pixel index within the frame, plus the delayed flag stage.
    int         pos [2];
    logic [2:0] dly [2];
    logic       fsm [2];

    function automatic int htot(input int c);
        return HA[c] + HF[c] + HS[c] + HB[c];
    endfunction

    function automatic int ftot(input int c);
        return htot(c) * (VA[c] + VF[c] + VS[c] + VB[c]);
    endfunction

    // {hsync, vsync, active} for a pixel index, straight from the timing rules.
    function automatic logic [2:0] decode(input int c, input int p);
        int x, y;
        logic h, v, a;
        x = p % htot(c);
        y = p / htot(c);
        h = !(x >= HA[c] + HF[c] && x < HA[c] + HF[c] + HS[c]);
        v = !(y >= VA[c] + VF[c] && y < VA[c] + VF[c] + VS[c]);
        a = (x < HA[c]) && (y < VA[c]);
        return {h, v, a};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            pos[c] = ftot(c) - 1;
            dly[c] = 3'b110;
            fsm[c] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic en, input logic rn);
        for (int c = 0; c < 2; c++) begin
            if (!rn) begin
                pos[c] = ftot(c) - 1;
                dly[c] = 3'b110;
                fsm[c] = 1'b0;
            end else if (en) begin
                dly[c] = decode(c, pos[c]);
                pos[c] = (pos[c] + 1) % ftot(c);
                fsm[c] = (pos[c] == 0);
            end else begin
                fsm[c] = 1'b0;
            end
        end
    endtask

    function automatic logic [23:0] expected(input int c);
        logic [9:0] ex, ey;
        logic [2:0] f;
        ex = 10'(pos[c] % htot(c));
        ey = 10'(pos[c] / htot(c));
`ifdef SYNC_DELAY_EN
        f = dly[c];
`else
        f = decode(c, pos[c]);
`endif
        return {ex, ey, f, fsm[c]};
    endfunction

    // One clock: update the model for the edge just taken, optionally assert reset
    // asynchronously, queue the expectation, then set up inputs for the next edge.
    task automatic step(input logic next_en, input logic next_rn);
        @(posedge clk);
        #2;
        cyc++;
        model_edge(pix_en, rst_n);
        if (!next_rn && rst_n) begin
            rst_n = 1'b0;
            model_reset();
        end
        q0.push_back(expected(0));
        q1.push_back(expected(1));
        rst_n  = next_rn;
        pix_en = next_en;
    endtask

    task automatic compare(input int c, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL dut%0d cyc=%0d got x=%0d y=%0d hs=%b vs=%b act=%b fs=%b expected x=%0d y=%0d hs=%b vs=%b act=%b fs=%b",
                     c, cyc, got[23:14], got[13:4], got[3], got[2], got[1], got[0],
                     exp[23:14], exp[13:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Monitor: every clock the DUTs present a new output set; pop and compare mid-cycle.
    always @(negedge clk) begin
        if (q0.size() > 0) compare(0, {x0, y0, hs0, vs0, act0, fs0}, q0.pop_front());
        if (q1.size() > 0) compare(1, {x1, y1, hs1, vs1, act1, fs1}, q1.pop_front());
    end

    initial begin
        logic mid_done;
        model_reset();
        mid_done = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        // Continuous enable: covers line wrap, hsync window and small-frame wraps.
        for (int i = 0; i < 2000; i++) step(1'b1, 1'b1);
        // Alternating enable.
        for (int i = 0; i < 1700; i++) step(i[0], 1'b1);
        // Random enable, with an asynchronous reset dropped in at x=300.
        for (int i = 0; i < 2500; i++) begin
            if (!mid_done && (pos[0] % htot(0)) == 300 && pos[0] > htot(0)) begin
                mid_done = 1'b1;
                step(1'($urandom_range(0, 1)), 1'b0);
                for (int k = 0; k < 3; k++) step(1'($urandom_range(0, 1)), 1'b0);
                step(1'b1, 1'b1);
            end else begin
                step(1'($urandom_range(0, 3) != 0), 1'b1);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (q0.size() != 0 || q1.size() != 0 || !mid_done) begin
            errors++;
            $display("FAIL drain q0=%0d q1=%0d mid_reset=%b expected 0 0 1", q0.size(), q1.size(), mid_done);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
